// File: rtl/execute_memory_pkg.sv
// Shared definitions for the execute->memory pipeline latch.
package execute_memory_pkg;

    localparam int unsigned DefaultWidth = 32;

    // Instruction word used for bubbles
    localparam logic [31:0] Nop = 32'h0;

    // 2-bit state encoding; the spare codes fall back to StIdle
    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StWait = 2'b01;

endpackage

// File: rtl/execute_memory_if.sv
// Execute-stage to memory-stage bundle, including the mult/div return path.
interface execute_memory_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] instruction;
    logic [WIDTH-1:0] pc;
    logic             ex_valid;
    logic             md_start;
    logic             md_ready;
    logic [WIDTH-1:0] md_result;
    logic             md_exception;
    logic             flush;
    logic [WIDTH-1:0] result_out;
    logic [WIDTH-1:0] dataB_out;
    logic [WIDTH-1:0] instruction_out;
    logic [WIDTH-1:0] pc_out;
    logic             valid_out;
    logic             exception_out;
    logic             stall;

    // Execute side / environment
    modport master (
        output alu_result, dataB, instruction, pc, ex_valid, md_start,
               md_ready, md_result, md_exception, flush,
        input  result_out, dataB_out, instruction_out, pc_out, valid_out,
               exception_out, stall
    );

    // Pipeline latch
    modport slave (
        input  alu_result, dataB, instruction, pc, ex_valid, md_start,
               md_ready, md_result, md_exception, flush,
        output result_out, dataB_out, instruction_out, pc_out, valid_out,
               exception_out, stall
    );
endinterface

// File: rtl/execute_memory_reg.sv
// Enabled register with asynchronous active-high reset to zero.
module execute_memory_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;

    // Load on enable, clear on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/execute_memory.sv
// Execute->memory pipeline latch with mult/div hold, flush bubbles and timeout.
module execute_memory
    import execute_memory_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    execute_memory_if.slave   bus
);
    localparam int unsigned    CntW    = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MD_TIMEOUT - 1);
    localparam logic [WIDTH-1:0] NopW   = WIDTH'(Nop);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic             out_en, hold_en, stall;
    logic [WIDTH-1:0] res_d, db_d, ins_d, pc_d;
    logic             vld_d, exc_d;
    logic [WIDTH-1:0] hold_ins, hold_db, hold_pc;

    // FSM state and WAIT-cycle counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, register enables and output-register inputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_en  = 1'b0;
        hold_en = 1'b0;
        stall   = 1'b0;
        res_d   = bus.alu_result;
        db_d    = bus.dataB;
        ins_d   = bus.instruction;
        pc_d    = bus.pc;
        vld_d   = 1'b0;
        exc_d   = 1'b0;
        if (bus.flush) begin
            // Squash wins over everything, including a same-cycle md_ready
            out_en  = 1'b1;
            ins_d   = NopW;
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    out_en = 1'b1;
                    cnt_d  = '0;
                    if (bus.ex_valid && bus.md_start) begin
                        hold_en = 1'b1;
                        stall   = 1'b1;
                        ins_d   = NopW;
                        state_d = StWait;
                    end else if (bus.ex_valid) begin
                        vld_d = 1'b1;
                    end else begin
                        ins_d = NopW;
                    end
                end
                StWait: begin
                    if (bus.md_ready || (cnt_q == CntLast)) begin
                        // Completion or timeout: release execute so the held op is not reissued
                        out_en  = 1'b1;
                        res_d   = bus.md_ready ? bus.md_result : '0;
                        exc_d   = bus.md_ready ? bus.md_exception : 1'b1;
                        db_d    = hold_db;
                        ins_d   = hold_ins;
                        pc_d    = hold_pc;
                        vld_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    out_en  = 1'b1;
                    ins_d   = NopW;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign bus.stall = stall;

    execute_memory_reg #(.WIDTH(WIDTH)) u_hold_ins (
        .clk_i(clock), .rst_i(reset), .en_i(hold_en), .d_i(bus.instruction), .q_o(hold_ins)
    );
    execute_memory_reg #(.WIDTH(WIDTH)) u_hold_db (
        .clk_i(clock), .rst_i(reset), .en_i(hold_en), .d_i(bus.dataB), .q_o(hold_db)
    );
    execute_memory_reg #(.WIDTH(WIDTH)) u_hold_pc (
        .clk_i(clock), .rst_i(reset), .en_i(hold_en), .d_i(bus.pc), .q_o(hold_pc)
    );

    execute_memory_reg #(.WIDTH(WIDTH)) u_res (
        .clk_i(clock), .rst_i(reset), .en_i(out_en), .d_i(res_d), .q_o(bus.result_out)
    );
    execute_memory_reg #(.WIDTH(WIDTH)) u_db (
        .clk_i(clock), .rst_i(reset), .en_i(out_en), .d_i(db_d), .q_o(bus.dataB_out)
    );
    execute_memory_reg #(.WIDTH(WIDTH)) u_ins (
        .clk_i(clock), .rst_i(reset), .en_i(out_en), .d_i(ins_d), .q_o(bus.instruction_out)
    );
    execute_memory_reg #(.WIDTH(WIDTH)) u_pc (
        .clk_i(clock), .rst_i(reset), .en_i(out_en), .d_i(pc_d), .q_o(bus.pc_out)
    );
    execute_memory_reg #(.WIDTH(1)) u_vld (
        .clk_i(clock), .rst_i(reset), .en_i(out_en), .d_i(vld_d), .q_o(bus.valid_out)
    );
    execute_memory_reg #(.WIDTH(1)) u_exc (
        .clk_i(clock), .rst_i(reset), .en_i(out_en), .d_i(exc_d), .q_o(bus.exception_out)
    );
endmodule
